// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared sequencer state encoding, opcodes and reset defaults
package core_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic [6:0]  OP_LOAD          = 7'b0000011;
    localparam logic [6:0]  OP_STORE         = 7'b0100011;
    localparam logic [6:0]  OP_SYSTEM        = 7'b1110011;
    localparam logic [2:0]  F3_PRIV          = 3'b000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - response wait counter; expired flags the last allowed waiting cycle
module wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = $clog2(TIMEOUT + 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // expired is judged on the count before this cycle's increment, so a
            // response in the TIMEOUT-th waiting cycle still wins
            assign expired = (cnt_q == CW'(TIMEOUT - 1));

            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (tick && !expired) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/EXEC/MEM/HALT sequencer owning PC and IR
module multicycle_ctrl
    import core_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT),
    parameter int unsigned           TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ifu_req,
    output logic [DATA_WIDTH-1:0] ifu_addr,
    input  logic                  ifu_rvalid,
    input  logic [31:0]           ifu_rdata,
    output logic [31:0]           inst,
    output logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] exu_upc,
    input  logic                  exu_jump,
    input  logic                  exu_reg_wen,
    output logic                  lsu_req,
    output logic                  lsu_wen,
    input  logic                  lsu_rvalid,
    output logic                  reg_wen,
    output logic                  exit,
    output logic                  err,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           inst_q, inst_d;
    logic                  exit_q, exit_d;
    logic                  err_q, err_d;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  is_load, is_store, is_mem, is_halt_op;
    logic                  waiting, resp, timer_expired;
    logic [DATA_WIDTH-1:0] pc_next;

    assign opcode     = inst_q[6:0];
    assign funct3     = inst_q[14:12];
    assign is_load    = (opcode == OP_LOAD);
    assign is_store   = (opcode == OP_STORE);
    assign is_mem     = is_mem_op(opcode);
    assign is_halt_op = (opcode == OP_SYSTEM) && (funct3 == F3_PRIV);

    assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign resp    = ((state_q == ST_FETCH) && ifu_rvalid) ||
                     ((state_q == ST_MEM) && lsu_rvalid);

    assign pc_next = exu_jump ? exu_upc : pc_q + DATA_WIDTH'(4);

    // Holding clear outside the waiting states and on a response means every
    // entry into FETCH or MEM starts from a zero count.
    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!waiting || resp),
        .tick    (waiting && !resp),
        .expired (timer_expired)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        exit_d  = exit_q;
        err_d   = err_q;
        case (state_q)
            ST_FETCH: begin
                if (ifu_rvalid) begin
                    inst_d  = ifu_rdata;
                    state_d = ST_EXEC;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_EXEC: begin
                if (is_halt_op) begin
                    exit_d  = 1'b1;
                    state_d = ST_HALT;
                end else if (is_mem) begin
                    state_d = ST_MEM;
                end else begin
                    pc_d    = pc_next;
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (lsu_rvalid) begin
                    pc_d    = pc_next;
                    state_d = ST_FETCH;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            exit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            exit_q  <= exit_d;
            err_q   <= err_d;
        end
    end

    // One write per instruction: in EXEC for ALU ops, in the response cycle for loads
    assign reg_wen = exu_reg_wen &&
                     (((state_q == ST_EXEC) && !is_mem && !is_halt_op) ||
                      ((state_q == ST_MEM) && lsu_rvalid && is_load));

    assign ifu_req  = (state_q == ST_FETCH);
    assign ifu_addr = pc_q;
    assign lsu_req  = (state_q == ST_MEM);
    assign lsu_wen  = lsu_req && is_store;
    assign busy     = (state_q != ST_HALT);
    assign inst     = inst_q;
    assign pc       = pc_q;
    assign exit     = exit_q;
    assign err      = err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] exu_upc;
    logic        exu_jump;
    logic        exu_reg_wen;
    logic        lsu_req;
    logic        lsu_wen;
    logic        lsu_rvalid;
    logic        reg_wen;
    logic        exit;
    logic        err;
    logic        busy;

    int passed;
    int total;
    int req_cycles;

    multicycle_ctrl #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h8000_0000),
        .TIMEOUT    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ifu_req     (ifu_req),
        .ifu_addr    (ifu_addr),
        .ifu_rvalid  (ifu_rvalid),
        .ifu_rdata   (ifu_rdata),
        .inst        (inst),
        .pc          (pc),
        .exu_upc     (exu_upc),
        .exu_jump    (exu_jump),
        .exu_reg_wen (exu_reg_wen),
        .lsu_req     (lsu_req),
        .lsu_wen     (lsu_wen),
        .lsu_rvalid  (lsu_rvalid),
        .reg_wen     (reg_wen),
        .exit        (exit),
        .err         (err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change just after a falling edge; checks follow 1ns later, well clear of posedge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        rst         = 1'b1;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = 32'h0;
        exu_upc     = 32'h0;
        exu_jump    = 1'b0;
        exu_reg_wen = 1'b0;
        lsu_rvalid  = 1'b0;

        repeat (2) @(posedge clk);
        next_cycle();
        #1;
        chk("rst_pc",   pc,   32'h8000_0000);
        chk("rst_inst", inst, 32'h0);
        chk("rst_exit", exit, 1'b0);
        chk("rst_err",  err,  1'b0);
        chk("rst_busy", busy, 1'b1);

        // zero-wait ALU instruction
        rst = 1'b0; ifu_rvalid = 1'b1; ifu_rdata = 32'h0050_0093; exu_reg_wen = 1'b1;
        #1;
        chk("alu_c1_addr",   ifu_addr, 32'h8000_0000);
        chk("alu_c1_req",    ifu_req,  1'b1);
        chk("alu_c1_regwen", reg_wen,  1'b0);
        next_cycle(); #1;
        chk("alu_c2_inst",   inst,    32'h0050_0093);
        chk("alu_c2_regwen", reg_wen, 1'b1);
        chk("alu_c2_req",    ifu_req, 1'b0);
        next_cycle(); #1;
        chk("alu_c3_pc",     pc,      32'h8000_0004);
        chk("alu_c3_regwen", reg_wen, 1'b0);

        // jump
        ifu_rdata = 32'h0000_006F; exu_reg_wen = 1'b0; exu_jump = 1'b1; exu_upc = 32'h8000_0100;
        next_cycle(); #1;
        chk("jmp_exec_regwen", reg_wen, 1'b0);
        next_cycle(); #1;
        chk("jmp_addr",   ifu_addr, 32'h8000_0100);
        chk("jmp_regwen", reg_wen,  1'b0);

        // load with three wait cycles
        ifu_rdata = 32'h0000_A103; exu_jump = 1'b0; exu_reg_wen = 1'b1;
        next_cycle(); #1;
        chk("ld_inst",        inst,    32'h0000_A103);
        chk("ld_exec_regwen", reg_wen, 1'b0);
        chk("ld_exec_lsureq", lsu_req, 1'b0);
        ifu_rvalid = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1;
            if (lsu_req) req_cycles++;
            chk("ld_wait_wen",    lsu_wen, 1'b0);
            chk("ld_wait_regwen", reg_wen, 1'b0);
        end
        next_cycle();
        lsu_rvalid = 1'b1;
        #1;
        if (lsu_req) req_cycles++;
        chk("ld_resp_regwen", reg_wen, 1'b1);
        chk("ld_resp_wen",    lsu_wen, 1'b0);
        chk("ld_req_cycles",  req_cycles, 4);
        next_cycle();
        lsu_rvalid = 1'b0;
        #1;
        chk("ld_done_pc",  pc,      32'h8000_0104);
        chk("ld_done_req", lsu_req, 1'b0);
        chk("ld_done_err", err,     1'b0);

        // store, with EXU intent held high to prove the gate
        ifu_rvalid = 1'b1; ifu_rdata = 32'h0020_A023;
        next_cycle();
        ifu_rvalid = 1'b0;
        #1;
        chk("st_exec_regwen", reg_wen, 1'b0);
        next_cycle();
        lsu_rvalid = 1'b1;
        #1;
        chk("st_lsureq", lsu_req, 1'b1);
        chk("st_lsuwen", lsu_wen, 1'b1);
        chk("st_regwen", reg_wen, 1'b0);
        next_cycle();
        lsu_rvalid = 1'b0;
        #1;
        chk("st_done_pc", pc, 32'h8000_0108);

        // system opcode -> exit
        ifu_rvalid = 1'b1; ifu_rdata = 32'h0010_0073;
        next_cycle(); #1;
        chk("ex_exec_exit", exit,    1'b0);
        chk("ex_exec_wen",  reg_wen, 1'b0);
        lsu_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1;
            chk("ex_halt_exit",   exit,    1'b1);
            chk("ex_halt_busy",   busy,    1'b0);
            chk("ex_halt_ifureq", ifu_req, 1'b0);
            chk("ex_halt_lsureq", lsu_req, 1'b0);
            chk("ex_halt_regwen", reg_wen, 1'b0);
            chk("ex_halt_pc",     pc,      32'h8000_0108);
            chk("ex_halt_inst",   inst,    32'h0010_0073);
        end

        // fetch timeout after four waiting cycles
        rst = 1'b1; ifu_rvalid = 1'b0; lsu_rvalid = 1'b0; exu_reg_wen = 1'b0;
        next_cycle(); #1;
        chk("to_rst_exit", exit, 1'b0);
        chk("to_rst_pc",   pc,   32'h8000_0000);
        rst = 1'b0;
        #1;
        chk("to_c1_req", ifu_req, 1'b1);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1;
            chk("to_wait_err",  err,  1'b0);
            chk("to_wait_busy", busy, 1'b1);
        end
        next_cycle(); #1;
        chk("to_err",    err,     1'b1);
        chk("to_busy",   busy,    1'b0);
        chk("to_ifureq", ifu_req, 1'b0);
        chk("to_exit",   exit,    1'b0);

        // response in the fourth waiting cycle is accepted
        rst = 1'b1;
        next_cycle(); #1;
        chk("to2_rst_err", err, 1'b0);
        rst = 1'b0;
        repeat (3) next_cycle();
        ifu_rvalid = 1'b1; ifu_rdata = 32'h0050_0093; exu_reg_wen = 1'b1;
        next_cycle();
        ifu_rvalid = 1'b0;
        #1;
        chk("to2_err",    err,     1'b0);
        chk("to2_inst",   inst,    32'h0050_0093);
        chk("to2_regwen", reg_wen, 1'b1);
        next_cycle(); #1;
        chk("to2_pc", pc, 32'h8000_0004);

        // reset while a load is pending
        ifu_rvalid = 1'b1; ifu_rdata = 32'h0000_A103;
        next_cycle();
        ifu_rvalid = 1'b0;
        next_cycle(); #1;
        chk("rm_lsureq", lsu_req, 1'b1);
        next_cycle();
        rst = 1'b1;
        #1;
        chk("rm_rst_regwen", reg_wen, 1'b0);
        next_cycle();
        rst = 1'b0; lsu_rvalid = 1'b1;
        #1;
        chk("rm_pc",     pc,      32'h8000_0000);
        chk("rm_inst",   inst,    32'h0);
        chk("rm_regwen", reg_wen, 1'b0);
        chk("rm_lsureq", lsu_req, 1'b0);
        chk("rm_ifureq", ifu_req, 1'b1);
        next_cycle();
        lsu_rvalid = 1'b0;
        #1;
        chk("rm_late_pc",     pc,      32'h8000_0000);
        chk("rm_late_regwen", reg_wen, 1'b0);
        chk("rm_late_busy",   busy,    1'b1);

        // PC wraps at the top of the address space
        ifu_rvalid = 1'b1; ifu_rdata = 32'h0000_0013; exu_reg_wen = 1'b0;
        exu_jump = 1'b1; exu_upc = 32'hFFFF_FFFC;
        next_cycle();
        next_cycle(); #1;
        chk("wrap_top", pc, 32'hFFFF_FFFC);
        exu_jump = 1'b0;
        next_cycle();
        next_cycle(); #1;
        chk("wrap_zero", pc, 32'h0000_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32 core, replacing the single-cycle top-level control. It owns the PC and instruction register, fetches over a valid/response handshake, runs loads and stores as a separate memory phase, and gates register-file writes to exactly one cycle per retired instruction. It detects the system opcode for simulation exit and raises a bus-timeout error. Decode, execute and the register file sit beside it and are driven from `inst` and `pc`.

## Interface
- `DATA_WIDTH`, 32: PC and address width.
- `RESET_PC`, 32'h8000_0000: PC loaded on reset.
- `TIMEOUT`, 255: maximum cycles to wait for a fetch or memory response; 0 disables the timeout.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ifu_req` output 1: fetch request, high throughout FETCH.
- `ifu_addr` output DATA_WIDTH: fetch address, equal to `pc`.
- `ifu_rvalid` input 1: fetch response valid.
- `ifu_rdata` input 32: fetched instruction.
- `inst` output 32: instruction register.
- `pc` output DATA_WIDTH: current PC.
- `exu_upc` input DATA_WIDTH: branch/jump target from EXU.
- `exu_jump` input 1: take `exu_upc`.
- `exu_reg_wen` input 1: EXU register-write intent, combinational from `inst`.
- `lsu_req` output 1: memory request, high throughout MEM.
- `lsu_wen` output 1: store qualifier, equal to `lsu_req` AND (opcode == STORE).
- `lsu_rvalid` input 1: memory response or store acknowledge.
- `reg_wen` output 1: gated register-file write enable.
- `exit` output 1: sticky; set on a system opcode.
- `err` output 1: sticky; set on timeout.
- `busy` output 1: high in any state other than HALT.

## Operation
- States: FETCH, EXEC, MEM, HALT.
- Reset state: FETCH, `pc`=RESET_PC, `inst`=0, `exit`=0, `err`=0, wait counter 0. A reset in any state, including mid-handshake, aborts the transaction, and any response in the following cycle is ignored.
- **FETCH:** `ifu_req`=1.
  - On `ifu_rvalid`: latch `ifu_rdata` into `inst` and go to EXEC.
  - A response in the same cycle as the first request is accepted (zero-wait memory).
- **EXEC:** exactly one cycle; `ifu_rvalid` and `lsu_rvalid` are ignored. Opcode = `inst[6:0]`.
  - opcode 1110011 with funct3 000: set `exit` and go to HALT. No register write, no PC change.
  - opcode 0000011 (LOAD) or 0100011 (STORE): go to MEM.
  - otherwise: `reg_wen`=`exu_reg_wen`, update the PC, go to FETCH.
- **MEM:** `lsu_req`=1.
  - On `lsu_rvalid`: `reg_wen`=`exu_reg_wen` (loads only; forced to 0 for stores), update the PC, go to FETCH.
- **HALT:** all request outputs 0, `reg_wen`=0, `busy`=0. Left only by `rst`.
- **PC update:** `pc` <= `exu_jump` ? `exu_upc` : `pc` + 4, modulo 2^DATA_WIDTH (wraps at the top of the address space). The PC changes only on EXEC→FETCH or MEM→FETCH.
- **Timeout** (FETCH and MEM, when TIMEOUT>0):
  - The counter clears on state entry.
  - Each cycle without a response: if counter == TIMEOUT-1, set `err` and go to HALT; otherwise increment.
  - A response in the TIMEOUT-th waiting cycle is still accepted.
  - Counter width is $clog2(TIMEOUT+1).
- `exit` and `err` never set in the same cycle.

## Timing
- Non-memory instruction with zero-wait responses: 2 cycles (FETCH, EXEC).
- Load/store with zero-wait responses: 3 cycles.
- Each wait cycle adds one.
- `reg_wen` is a single-cycle pulse, combinational from state and `exu_reg_wen`. At most one pulse per instruction.
- `ifu_req`, `lsu_req`, `lsu_wen` and `busy` are combinational from state and `inst`. There are no combinational paths from `*_rvalid` to any request output.
- `exit`/`err` are registered: they rise in the cycle after the deciding edge, and HALT is entered on that same edge.

## Structure
- Shared package `core_pkg`:
  - state enum;
  - opcode constants OP_LOAD, OP_STORE, OP_SYSTEM;
  - default RESET_PC.
- One sub-module, `wait_timer`:
  - parameter TIMEOUT;
  - inputs: clear, tick;
  - output: expired.
- The FSM, PC register and instruction register live in `multicycle_ctrl`.

## Test plan
- **Reset/zero-wait ALU:** release `rst`; `ifu_rvalid`=1 always; feed 0x00500093 (addi) with `exu_reg_wen`=1.
  - Expect `ifu_addr`=0x80000000.
  - Expect a `reg_wen` pulse in cycle 2.
  - Expect `pc`=0x80000004 in cycle 3.
- **Jump:** `exu_jump`=1, `exu_upc`=0x80000100 → next `ifu_addr`=0x80000100 and no extra `reg_wen`.
- **Load with 3 wait cycles:** `inst`=0x0000A103.
  - Expect `lsu_req` high for 4 cycles and `lsu_wen`=0.
  - Expect `reg_wen` only in the `lsu_rvalid` cycle.
  - Store 0x0020A023: `lsu_wen`=1 and `reg_wen`=0.
- **Exit:** fetch 0x00100073 → `exit`=1 and `busy`=0; further `ifu_rvalid` is ignored and `pc` stays frozen until `rst`.
- **Timeout:** TIMEOUT=4, `ifu_rvalid` held 0.
  - Expect `err`=1 after 4 waiting cycles.
  - A rerun with `ifu_rvalid` in waiting cycle 4 completes normally with `err`=0.
- **Reset mid-MEM:** assert `rst` during a pending load → FETCH, `pc`=RESET_PC, no `reg_wen`; a late `lsu_rvalid` is ignored.
